// File: rtl/scan_mux.sv
// Registered N-channel mux: manual select or a round-robin scan with a
// per-channel dwell time. All outputs come straight from flops.
module scan_mux #(
   parameter int N_CH = 7,
   parameter int W = 1,
   parameter int DWELL = 30,
   localparam int SW = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH*W-1:0] data,
   input  logic              mode,
   input  logic [SW-1:0]     sel,
   input  logic              hold,
   output logic [W-1:0]      y,
   output logic              y_valid,
   output logic [SW-1:0]     cur_ch,
   output logic              ch_change,
   output logic              wrap,
   output logic              sel_err
);

   localparam int DCW = $clog2(DWELL + 1);
   localparam logic [SW-1:0] LAST_CH = SW'(N_CH - 1);
   localparam logic [DCW-1:0] DC_LAST = DCW'(DWELL - 1);

   logic [W-1:0]   ch_arr [N_CH];
   logic [W-1:0]   y_q, y_d;
   logic           y_valid_q, y_valid_d;
   logic [SW-1:0]  cur_ch_q, cur_ch_d;
   logic [DCW-1:0] dwell_cnt_q, dwell_cnt_d;
   logic           ch_change_q, ch_change_d;
   logic           wrap_q, wrap_d;
   logic           sel_err_q, sel_err_d;

   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         ch_arr[k] = data[k*W +: W];
      end
   end

   // cur_ch_d is the next channel; manual mode keeps the dwell count at zero
   // so a later switch into scan always starts a fresh dwell period.
   always_comb begin
      cur_ch_d    = cur_ch_q;
      dwell_cnt_d = dwell_cnt_q;
      wrap_d      = 1'b0;
      sel_err_d   = 1'b0;
      if (!mode) begin
         dwell_cnt_d = '0;
         if (sel > LAST_CH) begin
            sel_err_d = 1'b1;
         end else begin
            cur_ch_d = sel;
         end
      end else if (!hold) begin
         if (dwell_cnt_q == DC_LAST) begin
            dwell_cnt_d = '0;
            if (cur_ch_q == LAST_CH) begin
               cur_ch_d = '0;
               wrap_d   = 1'b1;
            end else begin
               cur_ch_d = cur_ch_q + SW'(1);
            end
         end else begin
            dwell_cnt_d = dwell_cnt_q + DCW'(1);
         end
      end
      ch_change_d = (cur_ch_d != cur_ch_q);
      y_d         = ch_arr[cur_ch_d];
      y_valid_d   = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_q         <= '0;
         y_valid_q   <= 1'b0;
         cur_ch_q    <= '0;
         dwell_cnt_q <= '0;
         ch_change_q <= 1'b0;
         wrap_q      <= 1'b0;
         sel_err_q   <= 1'b0;
      end else begin
         y_q         <= y_d;
         y_valid_q   <= y_valid_d;
         cur_ch_q    <= cur_ch_d;
         dwell_cnt_q <= dwell_cnt_d;
         ch_change_q <= ch_change_d;
         wrap_q      <= wrap_d;
         sel_err_q   <= sel_err_d;
      end
   end

   assign y         = y_q;
   assign y_valid   = y_valid_q;
   assign cur_ch    = cur_ch_q;
   assign ch_change = ch_change_q;
   assign wrap      = wrap_q;
   assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux with N_CH=7, W=4, DWELL=4; channel k carries k+8.
// Expected output records are queued when inputs are driven, popped after the edge.
module tb_scan_mux;

   localparam int N_CH = 7;
   localparam int W = 4;
   localparam int DWELL = 4;
   localparam int SW = 3;
   localparam int DW = N_CH * W;

   typedef struct {
      logic [W-1:0]  y;
      logic          y_valid;
      logic [SW-1:0] cur_ch;
      logic          ch_change;
      logic          wrap;
      logic          sel_err;
   } exp_t;

   typedef struct {
      logic          mode;
      logic [SW-1:0] sel;
      logic          hold;
      exp_t          exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] data;
   logic          mode = 1'b0;
   logic [SW-1:0] sel = '0;
   logic          hold = 1'b0;
   logic [W-1:0]  y;
   logic          y_valid;
   logic [SW-1:0] cur_ch;
   logic          ch_change;
   logic          wrap;
   logic          sel_err;

   int   n_checks = 0;
   int   n_pass = 0;
   exp_t exp_q[$];
   vec_t vecs[$];

   always #5 clk = ~clk;

   scan_mux #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) dut (
      .clk(clk), .rst_n(rst_n), .data(data), .mode(mode), .sel(sel), .hold(hold),
      .y(y), .y_valid(y_valid), .cur_ch(cur_ch), .ch_change(ch_change),
      .wrap(wrap), .sel_err(sel_err)
   );

   function automatic logic [DW-1:0] base_data();
      logic [DW-1:0] d;
      for (int k = 0; k < N_CH; k++) d[k*W +: W] = W'(k + 8);
      return d;
   endfunction

   function automatic exp_t mk(int ch, logic chg, logic wr, logic err);
      exp_t e;
      e.y = W'(ch + 8);
      e.y_valid = 1'b1;
      e.cur_ch = SW'(ch);
      e.ch_change = chg;
      e.wrap = wr;
      e.sel_err = err;
      return e;
   endfunction

   function automatic exp_t zero_exp();
      exp_t e;
      e.y = '0;
      e.y_valid = 1'b0;
      e.cur_ch = '0;
      e.ch_change = 1'b0;
      e.wrap = 1'b0;
      e.sel_err = 1'b0;
      return e;
   endfunction

   task automatic check_output(input string name);
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("[TB] FAIL %s: scoreboard empty at t=%0t", name, $time);
         return;
      end
      e = exp_q.pop_front();
      if ({y, y_valid, cur_ch, ch_change, wrap, sel_err} !==
          {e.y, e.y_valid, e.cur_ch, e.ch_change, e.wrap, e.sel_err}) begin
         $display("[TB] FAIL %s t=%0t: got y=%h v=%b ch=%0d chg=%b wrap=%b err=%b, expected y=%h v=%b ch=%0d chg=%b wrap=%b err=%b",
                  name, $time, y, y_valid, cur_ch, ch_change, wrap, sel_err,
                  e.y, e.y_valid, e.cur_ch, e.ch_change, e.wrap, e.sel_err);
      end else begin
         n_pass++;
      end
   endtask

   task automatic apply_stimulus(input string name, input logic r, input logic m,
                                 input logic [SW-1:0] s, input logic h, input exp_t e);
      rst_n = r;
      mode = m;
      sel = s;
      hold = h;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_output(name);
   endtask

   initial begin
      exp_t e;
      data = base_data();

      for (int i = 0; i < 3; i++) begin
         data = DW'($urandom);
         apply_stimulus("reset", 1'b0, 1'($urandom_range(0, 1)),
                        SW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), zero_exp());
      end
      data = base_data();
      apply_stimulus("reset_release", 1'b1, 1'b0, 3'd0, 1'b0, mk(0, 0, 0, 0));

      // Manual-mode table; hold must have no effect outside scan mode.
      vecs.push_back('{1'b0, 3'd3, 1'b0, mk(3, 1, 0, 0)});
      vecs.push_back('{1'b0, 3'd3, 1'b0, mk(3, 0, 0, 0)});
      vecs.push_back('{1'b0, 3'd7, 1'b0, mk(3, 0, 0, 1)});
      vecs.push_back('{1'b0, 3'd3, 1'b0, mk(3, 0, 0, 0)});
      vecs.push_back('{1'b0, 3'd6, 1'b0, mk(6, 1, 0, 0)});
      vecs.push_back('{1'b0, 3'd7, 1'b0, mk(6, 0, 0, 1)});
      vecs.push_back('{1'b0, 3'd2, 1'b1, mk(2, 1, 0, 0)});
      vecs.push_back('{1'b0, 3'd0, 1'b0, mk(0, 1, 0, 0)});
      foreach (vecs[i]) begin
         apply_stimulus("manual", 1'b1, vecs[i].mode, vecs[i].sel, vecs[i].hold, vecs[i].exp);
      end

      for (int n = 1; n <= 28; n++) begin
         apply_stimulus("scan_walk", 1'b1, 1'b1, 3'd7, 1'b0,
                        mk((n / DWELL) % N_CH, (n % DWELL) == 0, n == 28, 0));
      end

      apply_stimulus("pre_hold", 1'b1, 1'b1, 3'd0, 1'b0, mk(0, 0, 0, 0));
      apply_stimulus("pre_hold", 1'b1, 1'b1, 3'd0, 1'b0, mk(0, 0, 0, 0));
      for (int i = 0; i < 5; i++) begin
         e = mk(0, 0, 0, 0);
         if (i >= 2) begin
            data[3:0] = 4'h3;
            e.y = 4'h3;
         end
         apply_stimulus("hold", 1'b1, 1'b1, 3'd0, 1'b1, e);
      end
      data = base_data();
      apply_stimulus("hold_release", 1'b1, 1'b1, 3'd0, 1'b0, mk(0, 0, 0, 0));
      apply_stimulus("hold_step", 1'b1, 1'b1, 3'd0, 1'b0, mk(1, 1, 0, 0));

      for (int n = 1; n <= 16; n++) begin
         apply_stimulus("scan_to_5", 1'b1, 1'b1, 3'd0, 1'b0,
                        mk(1 + n / DWELL, (n % DWELL) == 0, 0, 0));
      end
      apply_stimulus("scan_at_5", 1'b1, 1'b1, 3'd0, 1'b0, mk(5, 0, 0, 0));
      apply_stimulus("mid_reset", 1'b0, 1'b1, 3'd0, 1'b0, zero_exp());
      for (int n = 1; n <= 3; n++) begin
         apply_stimulus("resume", 1'b1, 1'b1, 3'd0, 1'b0, mk(0, 0, 0, 0));
      end
      apply_stimulus("resume_step", 1'b1, 1'b1, 3'd0, 1'b0, mk(1, 1, 0, 0));

      // Leaving scan takes sel at once; re-entering restarts the dwell period.
      apply_stimulus("to_manual", 1'b1, 1'b0, 3'd4, 1'b0, mk(4, 1, 0, 0));
      for (int n = 1; n <= 3; n++) begin
         apply_stimulus("to_scan", 1'b1, 1'b1, 3'd0, 1'b0, mk(4, 0, 0, 0));
      end
      apply_stimulus("to_scan_step", 1'b1, 1'b1, 3'd0, 1'b0, mk(5, 1, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
